// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the up/down modulo counter slice.
//   - count_mode_e : boundary behaviour (wrap around or hold at the end)
//   - clog2_safe   : ceil(log2(value)), never less than 1, so that a
//                    counter sized with it always has at least one bit
//   - COUNTER_CHECK_RANGE : elaboration-time legality check for integer
//                    parameters; expands to a named generate block that
//                    stops elaboration with $fatal when out of range.

`ifndef COUNTER_PKG_MACROS
`define COUNTER_PKG_MACROS
`define COUNTER_CHECK_RANGE(BLK, VALUE, LO, HI, MSG) \
  if ((longint'(VALUE) < longint'(LO)) || (longint'(VALUE) > longint'(HI))) begin : BLK \
    $fatal(1, MSG); \
  end
`endif

package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } count_mode_e;

  function automatic int clog2_safe(input longint unsigned value);
    int r;
    r = 0;
    while ((64'd1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler.sv
// counter_prescaler
//   Divides qualified enable cycles by PRESCALE. tick is high on the en
//   cycle in which the internal count reaches PRESCALE-1; the count then
//   returns to 0. The count only advances while en=1 and holds otherwise.
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous active-high reset, count to 0
//     en      qualified enable; advances the count
//     restart synchronous restart of the count to 0 (clr or load)
//     tick    combinational step request for the owning counter
//   With PRESCALE=1 the count can never leave 0, so tick reduces to en
//   and synthesis removes the register.

import counter_pkg::*;

module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  `COUNTER_CHECK_RANGE(g_chk_prescale, PRESCALE, 1, 65536, "counter_prescaler: PRESCALE out of range 1..65536")

  localparam int CW = clog2_safe(longint'(PRESCALE));
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          at_last;

  assign at_last = (cnt_reg == LAST);
  assign tick    = en && at_last;

  always_comb begin
    cnt_next = cnt_reg;
    if (restart) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = at_last ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod
//   Parametrised synchronous up/down modulo counter with parallel load,
//   synchronous clear, wrap or saturate boundary mode, optional prescaler,
//   a one-cycle terminal-count pulse and a sticky overflow flag.
//   Ports:
//     clk       rising-edge clock
//     reset     synchronous active-high reset (out, tc, ovf, prescaler)
//     en        count enable, qualifies prescaler and step
//     up        1 = increment, 0 = decrement
//     clr       synchronous clear of out, ovf, tc and prescaler
//     load      parallel load strobe (value clamped to MODULUS-1)
//     load_val  value to load
//     out       registered count, always in 0..MODULUS-1
//     tc        registered pulse, high the cycle after a boundary event
//     ovf       sticky flag, set by any boundary event, cleared by clr/reset
//   Edge priority: reset > clr > load > step > hold.

import counter_pkg::*;

module counter_updown_mod #(
  parameter int      WIDTH    = 4,
  parameter longint  MODULUS  = 16,
  parameter int      SATURATE = 0,
  parameter int      PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  `COUNTER_CHECK_RANGE(g_chk_width, WIDTH, 1, 32, "counter_updown_mod: WIDTH out of range 1..32")
  `COUNTER_CHECK_RANGE(g_chk_modulus, MODULUS, 2, (longint'(1) << WIDTH), "counter_updown_mod: MODULUS out of range 2..2**WIDTH")
  `COUNTER_CHECK_RANGE(g_chk_saturate, SATURATE, 0, 1, "counter_updown_mod: SATURATE must be 0 or 1")

  localparam count_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  // MODULUS-1 is formed in 64 bits before narrowing so that
  // MODULUS = 2**WIDTH yields all-ones rather than a truncated value.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'sd1);

  logic             tick;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clr | load),
    .tick    (tick)
  );

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    ovf_next   = ovf_reg;
    if (clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (load) begin
      count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (tick) begin
      if (up) begin
        if (count_reg == MAX_VAL) begin
          tc_next    = 1'b1;
          ovf_next   = 1'b1;
          count_next = (MODE == CNT_SAT) ? MAX_VAL : '0;
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else begin
        if (count_reg == '0) begin
          tc_next    = 1'b1;
          ovf_next   = 1'b1;
          count_next = (MODE == CNT_SAT) ? '0 : MAX_VAL;
        end else begin
          count_next = count_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign out = count_reg;
  assign tc  = tc_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Four counter configurations share one stimulus stream:
//   0: MODULUS=10 wrap, 1: MODULUS=10 saturate,
//   2: MODULUS=10 wrap PRESCALE=3, 3: MODULUS=16 wrap (full range).
// Each cycle the reference model pushes expected values to a queue before
// the edge; after the edge they are popped and compared against the DUTs.

module tb_counter_updown_mod;

  typedef struct {
    logic [3:0] out;
    logic       tc;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] out_a [4];
  logic       tc_a  [4];
  logic       ovf_a [4];

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  int m_mod [4] = '{10, 10, 10, 16};
  int m_sat [4] = '{0, 1, 0, 0};
  int m_pre [4] = '{1, 1, 3, 1};
  int s_cnt [4];
  int s_pre [4];
  int s_ovf [4];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a[0]), .tc(tc_a[0]), .ovf(ovf_a[0]));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a[1]), .tc(tc_a[1]), .ovf(ovf_a[1]));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) dut_pre (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a[2]), .tc(tc_a[2]), .ovf(ovf_a[2]));

  counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) dut_full (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a[3]), .tc(tc_a[3]), .ovf(ovf_a[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Integer reference: the step is computed as cnt+/-1 and then tested
  // against the range 0..MODULUS-1.
  task automatic model(input int i, output exp_t e);
    int nxt;
    int tcv;
    tcv = 0;
    if (reset) begin
      s_cnt[i] = 0; s_pre[i] = 0; s_ovf[i] = 0;
    end else if (clr) begin
      s_cnt[i] = 0; s_pre[i] = 0; s_ovf[i] = 0;
    end else if (load) begin
      s_cnt[i] = (int'(load_val) < m_mod[i]) ? int'(load_val) : m_mod[i] - 1;
      s_pre[i] = 0;
    end else if (en) begin
      if (s_pre[i] == m_pre[i] - 1) begin
        s_pre[i] = 0;
        nxt = up ? s_cnt[i] + 1 : s_cnt[i] - 1;
        if (nxt >= m_mod[i]) begin
          tcv = 1; s_ovf[i] = 1;
          s_cnt[i] = (m_sat[i] != 0) ? m_mod[i] - 1 : 0;
        end else if (nxt < 0) begin
          tcv = 1; s_ovf[i] = 1;
          s_cnt[i] = (m_sat[i] != 0) ? 0 : m_mod[i] - 1;
        end else begin
          s_cnt[i] = nxt;
        end
      end else begin
        s_pre[i] = s_pre[i] + 1;
      end
    end
    e.out = 4'(s_cnt[i]);
    e.tc  = (tcv != 0);
    e.ovf = (s_ovf[i] != 0);
  endtask

  task automatic cycle(input logic r, input logic e, input logic u,
                       input logic c, input logic l, input logic [3:0] lv);
    exp_t ex;
    reset = r; en = e; up = u; clr = c; load = l; load_val = lv;
    for (int i = 0; i < 4; i++) begin
      model(i, ex);
      exp_q.push_back(ex);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ex = exp_q.pop_front();
      check($sformatf("dut%0d_out", i), 32'(out_a[i]), 32'(ex.out));
      check($sformatf("dut%0d_tc", i),  32'(tc_a[i]),  32'(ex.tc));
      check($sformatf("dut%0d_ovf", i), 32'(ovf_a[i]), 32'(ex.ovf));
    end
    $display("cyc r=%0b en=%0b up=%0b clr=%0b ld=%0b lv=%0d | out=%0d/%0d/%0d/%0d tc=%0b%0b%0b%0b ovf=%0b%0b%0b%0b",
             r, e, u, c, l, lv, out_a[0], out_a[1], out_a[2], out_a[3],
             tc_a[0], tc_a[1], tc_a[2], tc_a[3], ovf_a[0], ovf_a[1], ovf_a[2], ovf_a[3]);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;

    // Reset
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_out%0d", i), 32'(out_a[i]), 0);
      check($sformatf("reset_ovf%0d", i), 32'(ovf_a[i]), 0);
    end

    // Wrap up: 0..9, 0, 1
    for (int k = 1; k <= 11; k++) begin
      cycle(0, 1, 1, 0, 0, 0);
      if (k == 9) begin
        check("wrap_up_9", 32'(out_a[0]), 9);
        check("wrap_up_9_tc", 32'(tc_a[0]), 0);
      end
      if (k == 10) begin
        check("wrap_up_0", 32'(out_a[0]), 0);
        check("wrap_up_tc", 32'(tc_a[0]), 1);
        check("wrap_up_ovf", 32'(ovf_a[0]), 1);
        check("sat_up_hold", 32'(out_a[1]), 9);
      end
      if (k == 11) begin
        check("wrap_up_1", 32'(out_a[0]), 1);
        check("wrap_up_tc_low", 32'(tc_a[0]), 0);
        check("wrap_up_ovf_sticky", 32'(ovf_a[0]), 1);
        check("sat_up_tc_again", 32'(tc_a[1]), 1);
        check("pre_after_11", 32'(out_a[2]), 3);
      end
    end

    // Wrap down / saturate down from 0
    cycle(0, 0, 0, 1, 0, 0);
    check("clr_ovf", 32'(ovf_a[0]), 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("down_wrap_9", 32'(out_a[0]), 9);
    check("down_wrap_tc", 32'(tc_a[0]), 1);
    check("down_sat_0", 32'(out_a[1]), 0);
    check("down_sat_tc1", 32'(tc_a[1]), 1);
    cycle(0, 1, 0, 0, 0, 0);
    check("down_wrap_8", 32'(out_a[0]), 8);
    check("down_wrap_tc_once", 32'(tc_a[0]), 0);
    check("down_sat_tc2", 32'(tc_a[1]), 1);
    cycle(0, 1, 0, 0, 0, 0);
    check("down_wrap_7", 32'(out_a[0]), 7);
    check("down_sat_tc3", 32'(tc_a[1]), 1);
    check("down_sat_still_0", 32'(out_a[1]), 0);

    // Load clamp and priorities
    cycle(0, 0, 1, 0, 1, 4'd12);
    check("load_clamp", 32'(out_a[0]), 9);
    check("load_full_12", 32'(out_a[3]), 12);
    check("load_keeps_ovf", 32'(ovf_a[0]), 1);
    cycle(0, 0, 1, 1, 1, 4'd5);
    check("clr_beats_load", 32'(out_a[0]), 0);
    check("clr_beats_load_ovf", 32'(ovf_a[0]), 0);
    cycle(0, 1, 1, 0, 1, 4'd5);
    check("load_beats_step", 32'(out_a[0]), 5);
    check("load_beats_step_tc", 32'(tc_a[0]), 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("hold", 32'(out_a[0]), 5);

    // Prescaler with en gap
    cycle(0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 4; k++) cycle(0, 1, 1, 0, 0, 0);
    check("pre_step1", 32'(out_a[2]), 1);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check("pre_hold_gap", 32'(out_a[2]), 1);
    cycle(0, 1, 1, 0, 0, 0);
    check("pre_delayed", 32'(out_a[2]), 1);
    cycle(0, 1, 1, 0, 0, 0);
    check("pre_step2", 32'(out_a[2]), 2);

    // Reset mid-operation at out=7, prescaler=1
    cycle(0, 0, 1, 0, 1, 4'd7);
    cycle(0, 1, 1, 0, 0, 0);
    check("pre_at_7", 32'(out_a[2]), 7);
    cycle(1, 1, 1, 0, 0, 0);
    check("midrst_out", 32'(out_a[2]), 0);
    check("midrst_tc", 32'(tc_a[2]), 0);
    check("midrst_ovf", 32'(ovf_a[2]), 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    check("midrst_no_early", 32'(out_a[2]), 0);
    cycle(0, 1, 1, 0, 0, 0);
    check("midrst_first_step", 32'(out_a[2]), 1);

    // Full-range modulus wrap 15 -> 0
    cycle(0, 0, 1, 0, 1, 4'd15);
    check("full_15", 32'(out_a[3]), 15);
    cycle(0, 1, 1, 0, 0, 0);
    check("full_wrap_0", 32'(out_a[3]), 0);
    check("full_wrap_tc", 32'(tc_a[3]), 1);
    check("full_wrap_ovf", 32'(ovf_a[3]), 1);

    // Random mix
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
            ($urandom_range(15) == 0), ($urandom_range(7) == 0), 4'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
